// File: rtl/regfile_wb.sv
// regfile_wb: writeback unit for the single register file write port.
// ALU and load results are queued in an in-order FIFO and drained one
// entry per cycle. A per-register pending-write map and read-hazard
// flags are exported so decode can stall.
// Optional operand bypass from the FIFO is built when the macro
// REGFILE_WB_BYPASS_EN is defined. Without it, the byp_* outputs are tied to zero.
module regfile_wb #(
   parameter int RADDRWIDTH = 3,
   parameter int REGWIDTH   = 16,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [RADDRWIDTH-1:0]      alu_waddr,
   input  logic [REGWIDTH-1:0]        alu_wdata,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [RADDRWIDTH-1:0]      ld_waddr,
   input  logic [REGWIDTH-1:0]        ld_wdata,
   output logic                       we,
   output logic [RADDRWIDTH-1:0]      waddr,
   output logic [REGWIDTH-1:0]        wdata,
   input  logic [RADDRWIDTH-1:0]      raddr_a,
   input  logic [RADDRWIDTH-1:0]      raddr_b,
   output logic                       hazard_a,
   output logic                       hazard_b,
   output logic [2**RADDRWIDTH-1:0]   busy,
   output logic                       byp_hit_a,
   output logic [REGWIDTH-1:0]        byp_data_a,
   output logic                       byp_hit_b,
   output logic [REGWIDTH-1:0]        byp_data_b
);

   localparam int NREG = 2**RADDRWIDTH;
   localparam int PTRW = $clog2(DEPTH);
   localparam int CNTW = PTRW + 1;

   logic [PTRW-1:0]       head_q, head_d;
   logic [PTRW-1:0]       tail_q, tail_d;
   logic [CNTW-1:0]       count_q, count_d;
   logic [RADDRWIDTH-1:0] mem_addr_q [DEPTH];
   logic [RADDRWIDTH-1:0] mem_addr_d [DEPTH];
   logic [REGWIDTH-1:0]   mem_data_q [DEPTH];
   logic [REGWIDTH-1:0]   mem_data_d [DEPTH];

   logic                  not_empty;
   logic                  alu_enq;
   logic                  ld_enq;
   logic [PTRW-1:0]       ld_slot;
   logic [NREG-1:0]       busy_v;

   // Readiness looks only at the registered count; a drain in the same
   // cycle gives no extra credit. The load port is throttled when the ALU
   // might take a slot in the same cycle.
   always_comb begin
      not_empty = (count_q != '0);
      alu_ready = (count_q <= CNTW'(DEPTH - 1));
      ld_ready  = alu_valid ? (count_q <= CNTW'(DEPTH - 2))
                            : (count_q <= CNTW'(DEPTH - 1));
      alu_enq   = alu_valid && alu_ready && (alu_waddr != '0);
      ld_enq    = ld_valid && ld_ready && (ld_waddr != '0);
   end

   // Next-state for the FIFO: the ALU entry goes in first (older), the load entry behind it,
   // and the head pops whenever the FIFO holds something.
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      ld_slot    = tail_q + PTRW'(alu_enq);
      if (alu_enq) begin
         mem_addr_d[tail_q] = alu_waddr;
         mem_data_d[tail_q] = alu_wdata;
      end
      if (ld_enq) begin
         mem_addr_d[ld_slot] = ld_waddr;
         mem_data_d[ld_slot] = ld_wdata;
      end
      tail_d  = tail_q + PTRW'(alu_enq) + PTRW'(ld_enq);
      head_d  = head_q + PTRW'(not_empty);
      count_d = count_q + CNTW'(alu_enq) + CNTW'(ld_enq) - CNTW'(not_empty);
   end

   // FIFO state registers. Reset discards everything, even mid-drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr_q[i] <= '0;
            mem_data_q[i] <= '0;
         end
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
      end
   end

   // Register file write port comes straight from the FIFO head.
   // When the FIFO is empty, the port is driven to zero.
   always_comb begin
      we    = not_empty;
      waddr = not_empty ? mem_addr_q[head_q] : '0;
      wdata = not_empty ? mem_data_q[head_q] : '0;
   end

   // Pending-write map. This covers every live entry from the head up to count;
   // the head entry stays pending until it pops.
   always_comb begin
      busy_v = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k < int'(count_q)) begin
            busy_v[mem_addr_q[head_q + PTRW'(k)]] = 1'b1;
         end
      end
      busy_v[0] = 1'b0;
      busy      = busy_v;
      hazard_a  = busy_v[raddr_a];
      hazard_b  = busy_v[raddr_b];
   end

`ifdef REGFILE_WB_BYPASS_EN
   // Bypass scans from oldest to youngest so the youngest match wins.
   always_comb begin
      byp_data_a = '0;
      byp_data_b = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k < int'(count_q)) begin
            if (mem_addr_q[head_q + PTRW'(k)] == raddr_a) begin
               byp_data_a = mem_data_q[head_q + PTRW'(k)];
            end
            if (mem_addr_q[head_q + PTRW'(k)] == raddr_b) begin
               byp_data_b = mem_data_q[head_q + PTRW'(k)];
            end
         end
      end
      byp_hit_a = hazard_a;
      byp_hit_b = hazard_b;
   end
`else
   // Bypass disabled: outputs tied off, no match logic.
   always_comb begin
      byp_hit_a  = 1'b0;
      byp_data_a = '0;
      byp_hit_b  = 1'b0;
      byp_data_b = '0;
   end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Testbench for regfile_wb: queue scoreboard plus directed checks.
module tb_regfile_wb;

   localparam int RW    = 3;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int NREG  = 2**RW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alu_valid = 1'b0;
   logic            alu_ready;
   logic [RW-1:0]   alu_waddr = '0;
   logic [DW-1:0]   alu_wdata = '0;
   logic            ld_valid = 1'b0;
   logic            ld_ready;
   logic [RW-1:0]   ld_waddr = '0;
   logic [DW-1:0]   ld_wdata = '0;
   logic            we;
   logic [RW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic [RW-1:0]   raddr_a = '0;
   logic [RW-1:0]   raddr_b = '0;
   logic            hazard_a;
   logic            hazard_b;
   logic [NREG-1:0] busy;
   logic            byp_hit_a;
   logic [DW-1:0]   byp_data_a;
   logic            byp_hit_b;
   logic [DW-1:0]   byp_data_b;

   typedef struct packed {
      logic [RW-1:0] a;
      logic [DW-1:0] d;
   } entry_t;

   entry_t sb[$];
   int     checks   = 0;
   int     failures = 0;
   bit     checking = 1'b0;

   regfile_wb #(.RADDRWIDTH(RW), .REGWIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
      .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b),
      .hazard_a(hazard_a), .hazard_b(hazard_b), .busy(busy),
      .byp_hit_a(byp_hit_a), .byp_data_a(byp_data_a),
      .byp_hit_b(byp_hit_b), .byp_data_b(byp_data_b)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Wait for the clock edge, then drive one cycle of producer inputs.
   task automatic applyStimulus(input logic av, input logic [RW-1:0] aa, input logic [DW-1:0] ad,
                                input logic lv, input logic [RW-1:0] la, input logic [DW-1:0] ld);
      @(posedge clk);
      #1;
      alu_valid = av; alu_waddr = aa; alu_wdata = ad;
      ld_valid  = lv; ld_waddr  = la; ld_wdata  = ld;
   endtask

   // Scoreboard. At each falling edge the DUT outputs are compared with the
   // model queue. The queue is then advanced to match what the next rising
   // edge will do: pop the head, push accepted non-r0 results, or flush on reset.
   always @(negedge clk) begin
      int              n;
      logic [NREG-1:0] mbusy;
      logic [DW-1:0]   mbyp_a, mbyp_b;
      logic            m_alu_r, m_ld_r;
      n = sb.size();
      mbusy = '0; mbyp_a = '0; mbyp_b = '0;
      foreach (sb[i]) begin
         mbusy[sb[i].a] = 1'b1;
         if (sb[i].a == raddr_a) mbyp_a = sb[i].d;
         if (sb[i].a == raddr_b) mbyp_b = sb[i].d;
      end
      m_alu_r = (n <= DEPTH - 1);
      m_ld_r  = alu_valid ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
      if (checking) begin
         if (n > 0) begin
            checkOutput("sb_we", 32'(we), 32'd1);
            checkOutput("sb_waddr", 32'(waddr), 32'(sb[0].a));
            checkOutput("sb_wdata", 32'(wdata), 32'(sb[0].d));
         end else begin
            checkOutput("sb_we_idle", 32'(we), 32'd0);
            checkOutput("sb_waddr_idle", 32'(waddr), 32'd0);
            checkOutput("sb_wdata_idle", 32'(wdata), 32'd0);
         end
         checkOutput("sb_busy", 32'(busy), 32'(mbusy));
         checkOutput("sb_hazard_a", 32'(hazard_a), 32'(mbusy[raddr_a]));
         checkOutput("sb_hazard_b", 32'(hazard_b), 32'(mbusy[raddr_b]));
         checkOutput("sb_alu_ready", 32'(alu_ready), 32'(m_alu_r));
         checkOutput("sb_ld_ready", 32'(ld_ready), 32'(m_ld_r));
`ifdef REGFILE_WB_BYPASS_EN
         checkOutput("sb_byp_hit_a", 32'(byp_hit_a), 32'(mbusy[raddr_a]));
         checkOutput("sb_byp_data_a", 32'(byp_data_a), 32'(mbyp_a));
         checkOutput("sb_byp_hit_b", 32'(byp_hit_b), 32'(mbusy[raddr_b]));
         checkOutput("sb_byp_data_b", 32'(byp_data_b), 32'(mbyp_b));
`else
         checkOutput("sb_byp_off", {byp_hit_a, byp_hit_b, byp_data_a ^ byp_data_b}, 32'd0);
`endif
      end
      if (rst) begin
         sb.delete();
         checking = 1'b1;
      end else if (checking) begin
         if (n > 0) void'(sb.pop_front());
         if (alu_valid && m_alu_r && alu_waddr != '0) sb.push_back('{a: alu_waddr, d: alu_wdata});
         if (ld_valid && m_ld_r && ld_waddr != '0) sb.push_back('{a: ld_waddr, d: ld_wdata});
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single ALU write: visible one cycle after acceptance, then gone.
      raddr_a = 3;
      applyStimulus(1, 3, 16'h1234, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t1_we", 32'(we), 32'd1);
      checkOutput("t1_waddr", 32'(waddr), 32'd3);
      checkOutput("t1_wdata", 32'(wdata), 32'h1234);
      checkOutput("t1_busy", 32'(busy), 32'h08);
      checkOutput("t1_hazard_a", 32'(hazard_a), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t1_we_after", 32'(we), 32'd0);
      checkOutput("t1_busy_after", 32'(busy), 32'd0);

      // Both producers in one cycle: the ALU result drains first.
      applyStimulus(1, 2, 16'h00AA, 1, 5, 16'h0055);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t2_first_addr", 32'(waddr), 32'd2);
      checkOutput("t2_first_data", 32'(wdata), 32'h00AA);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t2_second_addr", 32'(waddr), 32'd5);
      checkOutput("t2_second_data", 32'(wdata), 32'h0055);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t2_idle_we", 32'(we), 32'd0);

      // Sustained dual offer for four cycles.
      // Expected ld_ready per cycle is 1,1,0,0 for a depth of 4.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, RW'(i + 1), DW'(16'h0100 + i), 1, RW'(i + 4), DW'(16'h0200 + i));
         @(negedge clk);
         checkOutput("t3_alu_ready", 32'(alu_ready), 32'd1);
         checkOutput("t3_ld_ready", 32'(ld_ready), (i < 2) ? 32'd1 : 32'd0);
      end
      repeat (5) applyStimulus(0, 0, 0, 0, 0, 0);

      // Write to r0: the handshake completes but nothing is queued.
      applyStimulus(1, 0, 16'hFFFF, 0, 0, 0);
      @(negedge clk);
      checkOutput("t4_alu_ready", 32'(alu_ready), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t4_no_we", 32'(we), 32'd0);
      checkOutput("t4_busy", 32'(busy), 32'd0);

      // Two pending writes to r4: the younger (load) value is the bypass source.
      raddr_b = 4;
      applyStimulus(1, 4, 16'h0001, 1, 4, 16'h0002);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t5_hazard_b", 32'(hazard_b), 32'd1);
`ifdef REGFILE_WB_BYPASS_EN
      checkOutput("t5_byp_hit_b", 32'(byp_hit_b), 32'd1);
      checkOutput("t5_byp_data_b", 32'(byp_data_b), 32'h0002);
`else
      checkOutput("t5_byp_hit_b", 32'(byp_hit_b), 32'd0);
      checkOutput("t5_byp_data_b", 32'(byp_data_b), 32'd0);
`endif
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

      // Reset with three entries pending flushes the FIFO.
      applyStimulus(1, 1, 16'h1111, 1, 2, 16'h2222);
      applyStimulus(1, 3, 16'h3333, 1, 6, 16'h6666);
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t6_busy_before", 32'(busy), 32'h4C);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_we", 32'(we), 32'd0);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_alu_ready", 32'(alu_ready), 32'd1);
      checkOutput("t6_ld_ready", 32'(ld_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         checkOutput("t6_no_write", 32'(we), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
